seg_scan_mux: RTL

Downstream stage of the 7-segment decoder. Takes the decoded 8-bit segment patterns for NUM_DIGITS digits and drives them, one digit at a time, onto a shared segment bus with one-hot digit enables. A blanking interval at the start of each digit slot prevents ghosting. A double-buffered frame register keeps the displayed frame from tearing when new data arrives mid-scan.

---
 rtl/seg_scan_mux_if.sv | 37 +++
 rtl/seg_scan_mux.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux_if.sv
// ---------------------------------------------------------------------------
// seg_scan_mux_if
// Purpose : groups the data/strobe inputs and display outputs of the
//           multiplexed 7-segment scanner into one bundle.
// Signals : seg_in     - packed segment patterns, digit i at [8*i+7:8*i]
//           load       - single-cycle strobe capturing seg_in/digit_mask
//           digit_mask - 1 = digit lit, 0 = digit blank for its whole slot
//           seg        - shared segment bus, active-high (bit7 = dp)
//           an         - digit enables, one-hot or all-zero, active-high
//           frame_done - pulse marking the end of a full scan
//           bright     - 3-bit dimming level (only when SEG_DIM_EN defined)
// Modports: master drives the inputs (decoder side), slave is the scanner.
// Macro   : SEG_DIM_EN adds the bright signal.
// ---------------------------------------------------------------------------
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [8*NUM_DIGITS-1:0] seg_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   digit_mask;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;
`ifdef SEG_DIM_EN
  logic [2:0]              bright;

  modport master (output seg_in, load, digit_mask, bright,
                  input  seg, an, frame_done);
  modport slave  (input  seg_in, load, digit_mask, bright,
                  output seg, an, frame_done);
`else
  modport master (output seg_in, load, digit_mask,
                  input  seg, an, frame_done);
  modport slave  (input  seg_in, load, digit_mask,
                  output seg, an, frame_done);
`endif
endinterface

// File: rtl/seg_scan_mux.sv
// ---------------------------------------------------------------------------
// seg_scan_mux
// Purpose : time-multiplexes NUM_DIGITS decoded segment patterns onto one
//           segment bus with one-hot digit enables. Each digit slot starts
//           with a blanking interval to avoid ghosting; a shadow/active
//           double buffer keeps a frame from tearing when data arrives
//           mid-scan.
// Ports   : clk - system clock
//           rst - synchronous reset, active-high
//           bus - seg_scan_mux_if.slave (seg_in, load, digit_mask in;
//                 seg, an, frame_done out; bright in with SEG_DIM_EN)
// Macro   : SEG_DIM_EN enables per-slot brightness control via bus.bright.
// ---------------------------------------------------------------------------
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  seg_scan_mux_if.slave bus
);

  localparam int KW       = $clog2(SLOT_CYCLES);
  localparam int DW       = $clog2(NUM_DIGITS);
  localparam int SHOW_LEN = SLOT_CYCLES - BLANK_CYCLES;

  localparam logic [KW-1:0]         K_LAST  = KW'(SLOT_CYCLES - 1);
  localparam logic [KW-1:0]         K_BLANK = KW'(BLANK_CYCLES);
  localparam logic [DW-1:0]         D_LAST  = DW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE  = NUM_DIGITS'(1);

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_e;

  // Scan position
  logic [KW-1:0]           r_k;
  logic [DW-1:0]           r_d;
  // Double buffer
  logic [8*NUM_DIGITS-1:0] r_sh_data;
  logic [NUM_DIGITS-1:0]   r_sh_mask;
  logic [8*NUM_DIGITS-1:0] r_act_data;
  logic [NUM_DIGITS-1:0]   r_act_mask;
  // Output registers
  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  logic [KW-1:0]           w_k_nxt;
  logic [DW-1:0]           w_d_nxt;
  logic                    w_slot_end;
  logic                    w_boundary;
  phase_e                  w_phase;
  logic                    w_win;
  logic [7:0]              w_cur_seg;
  logic [7:0]              w_seg_nxt;
  logic [NUM_DIGITS-1:0]   w_an_nxt;

`ifdef SEG_DIM_EN
  logic [2:0]              r_bright;
  logic [31:0]             w_lim;

  // Brightness is latched at the first cycle of a slot and held for the slot;
  // k=0 is always blank, so the latched value is in place before SHOW.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bright <= 3'd0;
    end else if (r_k == '0) begin
      r_bright <= bus.bright;
    end
  end

  // Lit window length inside SHOW: (bright+1)/8 of the SHOW interval
  assign w_lim = ((32'(r_bright) + 32'd1) * 32'(SHOW_LEN)) >> 3;
  // Only evaluated while k >= BLANK_CYCLES, so the subtraction cannot wrap
  assign w_win = ((32'(r_k) - 32'(BLANK_CYCLES)) < w_lim);
`else
  assign w_win = 1'b1;
`endif

  // State register: slot counter and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k <= '0;
      r_d <= '0;
    end else begin
      r_k <= w_k_nxt;
      r_d <= w_d_nxt;
    end
  end

  // Next-state logic: k wraps at slot end, d advances and wraps per frame
  always_comb begin
    w_slot_end = (r_k == K_LAST);
    w_boundary = w_slot_end && (r_d == D_LAST);
    if (w_slot_end) begin
      w_k_nxt = '0;
      if (r_d == D_LAST) begin
        w_d_nxt = '0;
      end else begin
        w_d_nxt = r_d + DW'(1);
      end
    end else begin
      w_k_nxt = r_k + KW'(1);
      w_d_nxt = r_d;
    end
  end

  // Output decode for the current (d,k); registered one cycle later
  always_comb begin
    w_seg_nxt = 8'h00;
    w_an_nxt  = '0;
    w_cur_seg = r_act_data[{r_d, 3'b000} +: 8];
    w_phase   = (r_k < K_BLANK) ? PH_BLANK : PH_SHOW;
    case (w_phase)
      PH_BLANK: begin
        w_seg_nxt = 8'h00;
        w_an_nxt  = '0;
      end
      PH_SHOW: begin
        // seg is gated together with an so the bus is never driven unlit
        if (r_act_mask[r_d] && w_win) begin
          w_seg_nxt = w_cur_seg;
          w_an_nxt  = AN_ONE << r_d;
        end else begin
          w_seg_nxt = 8'h00;
          w_an_nxt  = '0;
        end
      end
      default: begin
        w_seg_nxt = 8'h00;
        w_an_nxt  = '0;
      end
    endcase
  end

  // Shadow captures every load; active swaps in only at the frame boundary.
  // A load on the boundary cycle bypasses the shadow so it is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_data  <= '0;
      r_sh_mask  <= '0;
      r_act_data <= '0;
      r_act_mask <= '0;
    end else begin
      if (bus.load) begin
        r_sh_data <= bus.seg_in;
        r_sh_mask <= bus.digit_mask;
      end
      if (w_boundary) begin
        r_act_data <= bus.load ? bus.seg_in     : r_sh_data;
        r_act_mask <= bus.load ? bus.digit_mask : r_sh_mask;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg        <= 8'h00;
      r_an         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_nxt;
      r_an         <= w_an_nxt;
      r_frame_done <= w_boundary;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.frame_done = r_frame_done;

endmodule
